// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encodings,
// datapath widths and small helper functions.
package mul_share_arbiter_pkg;

  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;
  localparam int MAX_REQ   = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_BUSY   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Round-robin pointer successor: w+1 wrapped at num_req.
  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w,
                                                 input int num_req);
    logic [IDX_W:0] n;
    n = {1'b0, w} + 3'd1;
    if (n >= 3'(num_req)) begin
      ptr_after = 2'd0;
    end else begin
      ptr_after = n[IDX_W-1:0];
    end
  endfunction

  // A product is trivially zero when either operand is zero.
  function automatic logic is_zero_pair(input logic [OPERAND_W-1:0] a,
                                        input logic [OPERAND_W-1:0] b);
    is_zero_pair = (a == 32'd0) || (b == 32'd0);
  endfunction

endpackage

// File: rtl/mul_share_arbiter_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching in wrap-around order. Reusable by other shared units.
module mul_share_arbiter_picker
  import mul_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] req_pad_s;
  logic [MAX_REQ-1:0] grant_pad_s;
  logic [IDX_W:0]     cand_s;
  logic               found_s;

  // Scan candidates ptr, ptr+1, ... (mod NUM_REQ) and keep the first hit.
  always_comb begin
    req_pad_s                = 4'd0;
    req_pad_s[NUM_REQ-1:0]   = req;
    grant_pad_s              = 4'd0;
    idx                      = 2'd0;
    found_s                  = 1'b0;
    cand_s                   = 3'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < NUM_REQ) begin
        cand_s = {1'b0, ptr} + 3'(k);
        if (cand_s >= 3'(NUM_REQ)) begin
          cand_s = cand_s - 3'(NUM_REQ);
        end else begin
          cand_s = cand_s;
        end
        if (!found_s && req_pad_s[cand_s[IDX_W-1:0]]) begin
          found_s                          = 1'b1;
          grant_pad_s[cand_s[IDX_W-1:0]]   = 1'b1;
          idx                              = cand_s[IDX_W-1:0];
        end else begin
          found_s = found_s;
        end
      end else begin
        found_s = found_s;
      end
    end
    grant = grant_pad_s[NUM_REQ-1:0];
    any   = found_s;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one iterative 32x32 multiplier among NUM_REQ requesters: round-robin
// grant, operand latching, start pulse, completion wait and result return.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [PRODUCT_W-1:0]           rsp_p,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [OPERAND_W-1:0]           mul_a,
  output logic [OPERAND_W-1:0]           mul_b,
  output logic                           mul_start,
  input  logic                           mul_finish,
  input  logic [PRODUCT_W-1:0]           mul_p,
  output logic [15:0]                    op_count
);

  state_e                 state_r, state_s;
  logic [IDX_W-1:0]       rr_ptr_r, owner_r, owner_next_s;
  logic [NUM_REQ-1:0]     req_ready_r, rsp_valid_r, rsp_onehot_s;
  logic [PRODUCT_W-1:0]   rsp_p_r;
  logic [OPERAND_W-1:0]   mul_a_r, mul_b_r, a_sel_s, b_sel_s;
  logic                   mul_start_r;
  logic [15:0]            op_count_r;
  logic [NUM_REQ-1:0]     pick_grant_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;
  logic                   do_grant_s, zero_s, owner_ack_s;
  logic [MAX_REQ-1:0]     rsp_ready_pad_s;

  mul_share_arbiter_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Select the winner's operands and resolve the owner's response handshake.
  always_comb begin
    a_sel_s         = 32'd0;
    b_sel_s         = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant_s[i]) begin
        a_sel_s = req_a[i*OPERAND_W +: OPERAND_W];
        b_sel_s = req_b[i*OPERAND_W +: OPERAND_W];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
    zero_s                   = is_zero_pair(a_sel_s, b_sel_s);
    rsp_ready_pad_s          = 4'd0;
    rsp_ready_pad_s[NUM_REQ-1:0] = rsp_ready;
    owner_ack_s              = rsp_ready_pad_s[owner_r];
  end

  // Next-state logic; grants are held off until the multiplier reports halt.
  always_comb begin
    state_s    = state_r;
    do_grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && mul_finish) begin
          do_grant_s = 1'b1;
          if (zero_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_LAUNCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_s = ST_SETTLE;
      ST_SETTLE: state_s = ST_BUSY;
      ST_BUSY: begin
        if (mul_finish) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        if (owner_ack_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // One-hot response vector for whichever requester owns the next cycle.
  always_comb begin
    owner_next_s = do_grant_s ? pick_idx_s : owner_r;
    rsp_onehot_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_next_s == 2'(i)) begin
        rsp_onehot_s[i] = 1'b1;
      end else begin
        rsp_onehot_s[i] = 1'b0;
      end
    end
  end

  // Control registers: state, pointer, owner and the registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= 2'd0;
      owner_r     <= 2'd0;
      req_ready_r <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      mul_start_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      mul_start_r <= (state_s == ST_LAUNCH);
      req_ready_r <= do_grant_s ? pick_grant_s : {NUM_REQ{1'b0}};
      rsp_valid_r <= (state_s == ST_RESP) ? rsp_onehot_s : {NUM_REQ{1'b0}};
      if (do_grant_s) begin
        owner_r  <= pick_idx_s;
        rr_ptr_r <= ptr_after(pick_idx_s, NUM_REQ);
      end
    end
  end

  // Operand and result registers; operands move only on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_r <= 32'd0;
      mul_b_r <= 32'd0;
      rsp_p_r <= 64'd0;
    end else if (do_grant_s) begin
      mul_a_r <= a_sel_s;
      mul_b_r <= b_sel_s;
      if (zero_s) begin
        rsp_p_r <= 64'd0;
      end
    end else if ((state_r == ST_BUSY) && mul_finish) begin
      rsp_p_r <= mul_p;
    end
  end

  // Completed-transaction counter, wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count_r <= 16'd0;
    end else if ((state_r == ST_RESP) && owner_ack_s) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_p     = rsp_p_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign mul_start = mul_start_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural iterative multiplier.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_p;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] mul_a, mul_b;
  logic        mul_start;
  logic        mul_finish = 1'b1;
  logic [63:0] mul_p = 64'd0;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  int mlat = 5;

  mul_share_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_finish(mul_finish),
    .mul_p(mul_p), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: start drops the halt level for mlat cycles.
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt       <= mlat;
      mul_finish <= 1'b0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt       <= 0;
      mul_finish <= 1'b1;
      mul_p      <= {32'd0, mul_a} * {32'd0, mul_b};
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic idx, input logic [31:0] a, input logic [31:0] b);
    if (idx) begin
      req_a[63:32] = a; req_b[63:32] = b;
    end else begin
      req_a[31:0] = a;  req_b[31:0] = b;
    end
    req_valid[idx] = 1'b1;
  endtask

  // Issue one request and step until a response is presented (no checks).
  task automatic run_txn(input logic idx, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic [1:0] rv, output int starts,
                         output int readies, output int since, output bit timeout);
    set_req(idx, a, b);
    starts = 0; readies = 0; since = -1; timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      cyc;
      if (mul_start) starts++;
      if (req_ready[idx]) begin
        readies++; req_valid[idx] = 1'b0; since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (rsp_valid != 2'b00) begin
        timeout = 1'b0;
        break;
      end
    end
    p = rsp_p; rv = rsp_valid; req_valid[idx] = 1'b0;
  endtask

  task automatic finish_rsp(input logic idx);
    rsp_ready[idx] = 1'b1;
    cyc;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc; cyc;
    checks++; if ({req_ready, rsp_valid, mul_start} !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {req_ready, rsp_valid, mul_start}); end
    checks++; if ({rsp_p, mul_a, mul_b} !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", {rsp_p, mul_a, mul_b}); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count got %h want 0", op_count); end
    checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr_r); end
    rst = 1'b1;
    cyc;
  endtask

  task automatic test_single;
    logic [63:0] p; logic [1:0] rv; int st, rd, since; bit to;
    run_txn(1'b0, 32'd7, 32'd6, p, rv, st, rd, since, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %0d want 0", to); end
    checks++; if (rd != 1) begin errors++; $display("FAIL single_ready_pulses got %0d want 1", rd); end
    checks++; if (st != 1) begin errors++; $display("FAIL single_start_pulses got %0d want 1", st); end
    checks++; if (since != 7) begin errors++; $display("FAIL single_latency got %0d want 7", since); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", rv); end
    checks++; if (p !== 64'd42) begin errors++; $display("FAIL single_product got %0d want 42", p); end
    checks++; if ({mul_a, mul_b} !== {32'd7, 32'd6}) begin errors++; $display("FAIL single_operands got %h want 0000000700000006", {mul_a, mul_b}); end
    finish_rsp(1'b0);
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", op_count); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_drop got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [1:0] own [2]; logic [63:0] prod [2]; int n = 0; int dual = 0;
    rst = 1'b0;
    set_req(1'b0, 32'd3, 32'd5);
    set_req(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc; cyc;
    rst = 1'b1;
    for (int c = 0; c < 200; c++) begin
      cyc;
      if (req_ready == 2'b11) dual++;
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (req_ready[1]) req_valid[1] = 1'b0;
      if (rsp_valid != 2'b00 && rsp_ready == 2'b00 && n < 2) begin
        own[n] = rsp_valid; prod[n] = rsp_p; n++;
        rsp_ready = rsp_valid;
      end else begin
        rsp_ready = 2'b00;
      end
      if (n == 2 && rsp_ready == 2'b00) break;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL cont_served got %0d want 2", n); end
    checks++; if (dual != 0) begin errors++; $display("FAIL cont_dual_grant got %0d want 0", dual); end
    if (n == 2) begin
      checks++; if (own[0] !== 2'b01) begin errors++; $display("FAIL cont_first_owner got %b want 01", own[0]); end
      checks++; if (prod[0] !== 64'd15) begin errors++; $display("FAIL cont_first_p got %h want f", prod[0]); end
      checks++; if (own[1] !== 2'b10) begin errors++; $display("FAIL cont_second_owner got %b want 10", own[1]); end
      checks++; if (prod[1] !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL cont_second_p got %h want fffffffe00000001", prod[1]); end
    end
    checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL cont_ptr got %0d want 0", dut.rr_ptr_r); end
    checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL cont_count got %0d want 2", op_count); end
  endtask

  task automatic test_zero;
    logic [63:0] p; logic [1:0] rv; int st, rd, since; bit to;
    run_txn(1'b0, 32'd0, 32'd123, p, rv, st, rd, since, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got %0d want 0", to); end
    checks++; if (since != 0) begin errors++; $display("FAIL zero_latency got %0d want 0", since); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL zero_rsp_valid got %b want 01", rv); end
    checks++; if (p !== 64'd0) begin errors++; $display("FAIL zero_product got %h want 0", p); end
    finish_rsp(1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc;
      if (mul_start) st++;
    end
    checks++; if (st != 0) begin errors++; $display("FAIL zero_start got %0d want 0", st); end
    checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL zero_count got %0d want 3", op_count); end
  endtask

  task automatic test_backpressure;
    logic [63:0] p; logic [1:0] rv; int st, rd, since; bit to;
    run_txn(1'b0, 32'd9, 32'd9, p, rv, st, rd, since, to);
    checks++; if (p !== 64'd81) begin errors++; $display("FAIL bp_product got %0d want 81", p); end
    set_req(1'b1, 32'd2, 32'd3);
    rsp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      cyc;
      checks++; if (rsp_p !== 64'd81) begin errors++; $display("FAIL bp_hold_p cyc %0d got %0d want 81", c, rsp_p); end
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 01", c, rsp_valid); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_grant cyc %0d got %b want 00", c, req_ready); end
    end
    rsp_ready = 2'b01;
    cyc;
    rsp_ready = 2'b00;
    checks++; if ({rsp_valid, req_ready} !== 4'b0000) begin errors++; $display("FAIL bp_handshake got %b want 0000", {rsp_valid, req_ready}); end
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL bp_count got %0d want 4", op_count); end
    cyc;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
    req_valid[1] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid != 2'b00) break;
      cyc;
    end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_second_valid got %b want 10", rsp_valid); end
    checks++; if (rsp_p !== 64'd6) begin errors++; $display("FAIL bp_second_p got %0d want 6", rsp_p); end
    finish_rsp(1'b1);
  endtask

  task automatic test_reset_busy;
    int held = 0;
    mlat = 20;
    set_req(1'b0, 32'd100, 32'd3);
    for (int c = 0; c < 50; c++) begin
      cyc;
      if (req_ready[0]) break;
    end
    req_valid[0] = 1'b0;
    cyc; cyc; cyc; cyc;
    rst = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, mul_start} !== 5'd0) begin errors++; $display("FAIL rstbusy_ctrl got %b want 0", {req_ready, rsp_valid, mul_start}); end
    checks++; if ({rsp_p, mul_a, mul_b} !== 128'd0) begin errors++; $display("FAIL rstbusy_data got %h want 0", {rsp_p, mul_a, mul_b}); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rstbusy_count got %0d want 0", op_count); end
    set_req(1'b1, 32'd4, 32'd5);
    cyc; cyc;
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (mul_finish) break;
      cyc;
      held++;
      checks++; if ({mul_start, req_ready} !== 3'b000) begin errors++; $display("FAIL rstbusy_hold cyc %0d got %b want 000", c, {mul_start, req_ready}); end
    end
    checks++; if (held == 0) begin errors++; $display("FAIL rstbusy_wait got %0d want >0", held); end
    mlat = 5;
    cyc;
    checks++; if ({req_ready, mul_start} !== 3'b101) begin errors++; $display("FAIL rstbusy_regrant got %b want 101", {req_ready, mul_start}); end
    req_valid[1] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid != 2'b00) break;
      cyc;
    end
    checks++; if ({rsp_valid, rsp_p} !== {2'b10, 64'd20}) begin errors++; $display("FAIL rstbusy_rsp got %b/%0d want 10/20", rsp_valid, rsp_p); end
    finish_rsp(1'b1);
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rstbusy_count2 got %0d want 1", op_count); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFF; exp_cnt[1] = 16'h0000; exp_cnt[2] = 16'h0001;
    force dut.op_count_r = 16'hFFFE;
    #1;
    release dut.op_count_r;
    #1;
    checks++; if (op_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got %h want fffe", op_count); end
    set_req(1'b0, 32'd0, 32'd5);
    rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cyc; cyc;
      checks++; if (op_count !== exp_cnt[k]) begin errors++; $display("FAIL wrap_step%0d got %h want %h", k, op_count, exp_cnt[k]); end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cyc;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_zero;
    test_backpressure;
    test_reset_busy;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
